// File: rtl/dmem_dump_streamer.sv
// rtl/dmem_dump_streamer.sv - streams a window of data memory out as valid/ready beats
//
// Reads word_count consecutive words starting at base_addr from a data memory
// with a 1-cycle synchronous read port and presents each word, with its
// address, on a valid/ready output. Used to drain results after a program run.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   start       pulse; begins a dump when idle (ignored while busy)
//   base_addr   first word address, sampled with an accepted start
//   word_count  words to dump, 0..2**ADDR_W, sampled with an accepted start
//   mem_rd_en   read strobe to data memory
//   mem_addr    read word address (holds its last value when not reading)
//   mem_rdata   read data, valid the cycle after mem_rd_en
//   out_valid   output beat valid
//   out_ready   sink accepts the beat
//   out_data    word read from memory
//   out_addr    address the word came from
//   out_last    final beat of the dump
//   busy        high from start acceptance until done
//   done        one-cycle pulse at the end of a dump
module dmem_dump_streamer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remaining;
   logic              handshake;

   assign handshake = (state == S_SEND) && out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_rd_en = 1'b0;
      mem_addr  = addr_q;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               // A zero-length dump still reports completion through FIN.
               state_nxt = (word_count != '0) ? S_ISSUE : S_FIN;
            end
         end
         S_ISSUE: begin
            mem_rd_en = 1'b1;
            mem_addr  = ptr;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = out_last ? S_FIN : S_ISSUE;
            end
         end
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // addr_q lets mem_addr keep the last issued address outside ISSUE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         remaining <= '0;
         addr_q    <= '0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
      end else begin
         addr_q <= mem_addr;
         if ((state == S_IDLE) && start && (word_count != '0)) begin
            ptr       <= base_addr;
            remaining <= word_count;
         end
         if (state == S_WAIT) begin
            out_data <= mem_rdata;
            out_addr <= ptr;
            out_last <= (remaining == REM_ONE);
         end
         if (handshake) begin
            // ADDR_W-bit add wraps the top address back to zero.
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - REM_ONE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// tb/tb_dmem_dump_streamer.sv - self-checking bench for dmem_dump_streamer
module tb_dmem_dump_streamer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [11:0] base_addr;
   logic [12:0] word_count;
   logic        mem_rd_en;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [11:0] out_addr;
   logic        out_last;
   logic        busy;
   logic        done;

   dmem_dump_streamer #(.ADDR_W(12), .DATA_W(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory contents: word at address a is 0xA0 + (a - 0x10).
   function automatic logic [31:0] pat(input logic [11:0] a);
      return 32'h000000A0 + {20'd0, a} - 32'h00000010;
   endfunction

   // Synchronous-read memory model, 1-cycle latency.
   always @(posedge clock) begin
      if (mem_rd_en) mem_rdata <= pat(mem_addr);
   end

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
      logic        l;
   } beat_t;

   beat_t       beatq[$];
   logic [11:0] rdq[$];
   int          beat_cyc[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int rd_cnt     = 0;
   int done_cnt   = 0;
   int done_cyc   = 0;
   int busy_cnt   = 0;
   int valid_cnt  = 0;
   int beats_seen = 0;
   int start_cyc  = 0;
   bit last_valid = 0;
   bit stall_pend = 0;
   logic [31:0] hold_d;
   logic [11:0] hold_a;
   logic        hold_l;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: observe at the falling edge, return 1 time unit after the rising edge.
   task automatic step();
      beat_t b;
      logic [11:0] ra;
      @(negedge clock);
      cyc++;
      last_valid = out_valid;
      if (mem_rd_en) begin
         rd_cnt++;
         if (rdq.size() == 0) chk("read_unexpected", {52'd0, mem_addr}, 64'hFFFF);
         else begin
            ra = rdq.pop_front();
            chk("read_addr", {52'd0, mem_addr}, {52'd0, ra});
         end
      end
      if (out_valid) begin
         valid_cnt++;
         if (stall_pend) begin
            chk("hold_data", {32'd0, out_data}, {32'd0, hold_d});
            chk("hold_addr", {52'd0, out_addr}, {52'd0, hold_a});
            chk("hold_last", {63'd0, out_last}, {63'd0, hold_l});
            chk("no_read_in_stall", {63'd0, mem_rd_en}, 64'd0);
         end
         if (!out_ready) begin
            stall_pend = 1;
            hold_d = out_data;
            hold_a = out_addr;
            hold_l = out_last;
         end else begin
            stall_pend = 0;
            if (beatq.size() == 0) chk("beat_unexpected", {52'd0, out_addr}, 64'hFFFF);
            else begin
               b = beatq.pop_front();
               chk("beat_addr", {52'd0, out_addr}, {52'd0, b.a});
               chk("beat_data", {32'd0, out_data}, {32'd0, b.d});
               chk("beat_last", {63'd0, out_last}, {63'd0, b.l});
            end
            beat_cyc.push_back(cyc);
            beats_seen++;
         end
      end else begin
         stall_pend = 0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      @(posedge clock);
      #1;
   endtask

   task automatic push_dump(input logic [11:0] base, input int count);
      logic [11:0] a;
      beat_t b;
      for (int i = 0; i < count; i++) begin
         a = base + 12'(i);
         rdq.push_back(a);
         b.a = a;
         b.d = pat(a);
         b.l = (i == count - 1);
         beatq.push_back(b);
      end
   endtask

   task automatic pulse_start(input logic [11:0] base, input logic [12:0] count);
      base_addr  = base;
      word_count = count;
      start      = 1'b1;
      start_cyc  = cyc + 1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cnt != d0) break;
      end
      chk("done_within_budget", {63'd0, done_cnt != d0}, 64'd1);
   endtask

   task automatic wait_beats(input int n, input int budget);
      int b0;
      b0 = beats_seen;
      for (int i = 0; i < budget; i++) begin
         if (beats_seen - b0 >= n) break;
         step();
      end
      chk("beats_within_budget", {63'd0, (beats_seen - b0) >= n}, 64'd1);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (last_valid) break;
      end
      chk("valid_within_budget", {63'd0, last_valid}, 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return {3'd0, mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done};
   endfunction

   initial begin
      int rd0, b0, busy0, valid0, d0, rdh;

      reset      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      out_ready  = 1'b0;
      repeat (3) step();
      chk("reset_outputs", all_outs(), 64'd0);
      reset = 1'b1;
      step();
      chk("idle_not_busy", {63'd0, busy}, 64'd0);

      // T1: four words from 0x010, sink always ready.
      out_ready = 1'b1;
      beat_cyc.delete();
      rd0 = rd_cnt;
      push_dump(12'h010, 4);
      pulse_start(12'h010, 13'd4);
      wait_done(40);
      chk("t1_nbeats", beat_cyc.size(), 64'd4);
      if (beat_cyc.size() == 4) begin
         chk("t1_first_valid_cycle", beat_cyc[0], start_cyc + 3);
         for (int i = 1; i < 4; i++) chk("t1_beat_spacing", beat_cyc[i] - beat_cyc[i-1], 64'd3);
         chk("t1_done_after_last", done_cyc, beat_cyc[3] + 1);
      end
      chk("t1_reads", rd_cnt - rd0, 64'd4);
      chk("t1_queues_empty", beatq.size() + rdq.size(), 64'd0);

      // T2: same dump, sink stalls 5 cycles on beat 2.
      push_dump(12'h010, 4);
      pulse_start(12'h010, 13'd4);
      wait_beats(1, 20);
      out_ready = 1'b0;
      rdh = rd_cnt;
      wait_valid(20);
      repeat (4) step();
      chk("t2_single_read_during_stall", rd_cnt - rdh, 64'd1);
      chk("t2_still_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      wait_done(40);
      chk("t2_queues_empty", beatq.size() + rdq.size(), 64'd0);

      // T3: address wrap from 0xFFE.
      push_dump(12'hFFE, 4);
      pulse_start(12'hFFE, 13'd4);
      wait_done(40);
      chk("t3_queues_empty", beatq.size() + rdq.size(), 64'd0);

      // T4: zero-length dump.
      rd0    = rd_cnt;
      b0     = beats_seen;
      busy0  = busy_cnt;
      valid0 = valid_cnt;
      pulse_start(12'h055, 13'd0);
      wait_done(10);
      step();
      chk("t4_done_cycle", done_cyc, start_cyc + 1);
      chk("t4_no_reads", rd_cnt - rd0, 64'd0);
      chk("t4_no_beats", beats_seen - b0, 64'd0);
      chk("t4_no_valid", valid_cnt - valid0, 64'd0);
      chk("t4_busy_cycles", busy_cnt - busy0, 64'd1);

      // T5: second start during beat 2 must be ignored.
      d0 = done_cnt;
      push_dump(12'h010, 4);
      pulse_start(12'h010, 13'd4);
      wait_beats(1, 20);
      step();
      pulse_start(12'h100, 13'd2);
      wait_done(40);
      step();
      chk("t5_single_done", done_cnt - d0, 64'd1);
      chk("t5_idle_after", {63'd0, busy}, 64'd0);
      chk("t5_queues_empty", beatq.size() + rdq.size(), 64'd0);

      // T6: reset while beat 2 is waiting in SEND.
      push_dump(12'h010, 4);
      pulse_start(12'h010, 13'd4);
      wait_beats(1, 20);
      out_ready = 1'b0;
      wait_valid(20);
      reset = 1'b0;
      #1;
      chk("t6_async_reset_outputs", all_outs(), 64'd0);
      rdq.delete();
      beatq.delete();
      stall_pend = 0;
      d0 = done_cnt;
      repeat (3) step();
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (2) step();
      chk("t6_no_done_after_abort", done_cnt - d0, 64'd0);
      chk("t6_idle_after_release", {63'd0, busy}, 64'd0);
      b0 = beats_seen;
      push_dump(12'h010, 4);
      pulse_start(12'h010, 13'd4);
      wait_done(40);
      chk("t6_rerun_beats", beats_seen - b0, 64'd4);
      chk("t6_queues_empty", beatq.size() + rdq.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
